// File: rtl/sd_ddr_load_ctrl.sv
// sd_ddr_load_ctrl: boot-time copier of SD sectors into DDR through a 512-word first-word-fall-through FIFO
module sd_ddr_load_ctrl #(
    parameter logic [31:0]       START_SECTOR  = 32'd8192,
    parameter logic [15:0]       NUM_SECTORS   = 16'd64,
    parameter int                ADDR_W        = 27,
    parameter logic [ADDR_W-1:0] DDR_BASE_ADDR = '0,
    parameter logic [15:0]       BUSY_TO       = 16'd50000
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic              sd_init_done,
    input  logic              init_calib_complete,
    input  logic              reload,
    output logic              sd_rd_start,
    output logic [31:0]       sd_rd_sec_addr,
    input  logic              sd_rd_busy,
    input  logic              sd_rd_val_en,
    input  logic [15:0]       sd_rd_val_data,
    output logic              ddr_wr_valid,
    input  logic              ddr_wr_rdy,
    output logic [ADDR_W-1:0] ddr_wr_addr,
    output logic [15:0]       ddr_wr_data,
    output logic              sys_init_done,
    output logic              load_err,
    output logic [1:0]        err_code
);
    localparam logic [9:0]  FIFO_DEPTH   = 10'd512;
    localparam logic [9:0]  ISSUE_MAX    = 10'd256;
    localparam logic [15:0] SECTOR_WORDS = 16'd256;

    typedef enum logic [2:0] {IDLE, WAIT_INIT, ISSUE, WAIT_BUSY, RECV, DRAIN, DONE, ERR} state_t;

    state_t      state, state_nx;
    logic [15:0] mem [512];
    logic [8:0]  wr_ptr, rd_ptr;
    logic [9:0]  fifo_cnt;
    logic        full, push, pop, ovf;
    logic        start_nx, done_nx, err_nx, clr, adv;
    logic [1:0]  code_nx;
    logic [15:0] word_cnt, last_cnt, sec_idx, busy_tmr;

    assign full         = fifo_cnt == FIFO_DEPTH;
    assign ddr_wr_valid = fifo_cnt != '0;
    assign ddr_wr_data  = mem[rd_ptr];
    assign pop          = ddr_wr_valid & ddr_wr_rdy;
    assign ovf          = sd_rd_val_en & full & ~pop;
    assign push         = sd_rd_val_en & ~ovf;
    // a push coinciding with busy falling still belongs to the sector
    assign last_cnt     = word_cnt + 16'(sd_rd_val_en);

    always_ff @(posedge sys_clk or posedge sys_rst)
        if (sys_rst) state <= IDLE;
        else state <= state_nx;

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:      state_nx = WAIT_INIT;
            WAIT_INIT: if (sd_init_done && init_calib_complete) state_nx = ISSUE;
            ISSUE:     if (fifo_cnt <= ISSUE_MAX && !sd_rd_busy) state_nx = WAIT_BUSY;
            WAIT_BUSY: if (sd_rd_busy) state_nx = RECV;
                       else if (busy_tmr == BUSY_TO - 16'd1) state_nx = ERR;
            RECV:      if (!sd_rd_busy) state_nx = last_cnt != SECTOR_WORDS ? ERR :
                                                   sec_idx + 16'd1 == NUM_SECTORS ? DRAIN : ISSUE;
            DRAIN:     if (!ddr_wr_valid) state_nx = DONE;
            DONE:      if (reload) state_nx = WAIT_INIT;
            ERR:       if (reload) state_nx = WAIT_INIT;
            default:   state_nx = IDLE;
        endcase
        if (ovf && state != ERR) state_nx = ERR;
    end

    always_comb begin
        start_nx = state == ISSUE && state_nx == WAIT_BUSY;
        done_nx  = state_nx == DONE;
        err_nx   = state_nx == ERR;
        code_nx  = !err_nx ? 2'd0 : state == ERR ? err_code : ovf ? 2'd3 : state == WAIT_BUSY ? 2'd1 : 2'd2;
        clr      = (state == DONE || state == ERR) && state_nx == WAIT_INIT;
        adv      = state == RECV && (state_nx == ISSUE || state_nx == DRAIN);
    end

    always_ff @(posedge sys_clk)
        if (push) mem[wr_ptr] <= sd_rd_val_data;

    always_ff @(posedge sys_clk or posedge sys_rst)
        if (sys_rst) begin
            sd_rd_start    <= 1'b0;
            sys_init_done  <= 1'b0;
            load_err       <= 1'b0;
            err_code       <= 2'd0;
            busy_tmr       <= '0;
            word_cnt       <= '0;
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            fifo_cnt       <= '0;
            sec_idx        <= '0;
            sd_rd_sec_addr <= START_SECTOR;
            ddr_wr_addr    <= DDR_BASE_ADDR;
        end else begin
            sd_rd_start   <= start_nx;
            sys_init_done <= done_nx;
            load_err      <= err_nx;
            err_code      <= code_nx;
            busy_tmr      <= start_nx ? '0 : busy_tmr + 16'(state == WAIT_BUSY);
            word_cnt      <= start_nx ? '0 :
                             (state == WAIT_BUSY || state == RECV) && sd_rd_val_en && word_cnt != '1 ? word_cnt + 16'd1 : word_cnt;
            if (clr) begin
                wr_ptr         <= '0;
                rd_ptr         <= '0;
                fifo_cnt       <= '0;
                sec_idx        <= '0;
                sd_rd_sec_addr <= START_SECTOR;
                ddr_wr_addr    <= DDR_BASE_ADDR;
            end else begin
                wr_ptr      <= wr_ptr + 9'(push);
                rd_ptr      <= rd_ptr + 9'(pop);
                fifo_cnt    <= fifo_cnt + 10'(push) - 10'(pop);
                ddr_wr_addr <= ddr_wr_addr + ADDR_W'(pop);
                if (adv) begin
                    sec_idx        <= sec_idx + 16'd1;
                    sd_rd_sec_addr <= sd_rd_sec_addr + 32'd1;
                end
            end
        end
endmodule

// File: tb/tb_sd_ddr_load_ctrl.sv
// tb_sd_ddr_load_ctrl: directed bench with an SD reader model and a DDR sink scoreboard
module tb_sd_ddr_load_ctrl;
    logic        sys_clk = 0, sys_rst = 1, sd_init_done = 0, init_calib_complete = 0, reload = 0;
    logic        sd_rd_busy = 0, sd_rd_val_en = 0, ddr_wr_rdy = 0;
    logic [15:0] sd_rd_val_data = 0;
    logic        sd_rd_start, ddr_wr_valid, sys_init_done, load_err;
    logic [31:0] sd_rd_sec_addr;
    logic [26:0] ddr_wr_addr;
    logic [15:0] ddr_wr_data;
    logic [1:0]  err_code;

    int n_cmp = 0, n_bad = 0;
    int push_idx = 0, pop_idx = 0, n_push = 0, n_starts = 0, cyc = 0, last_pop = 0;
    int rdy_mode = 0, rdy_ctr = 0;
    logic        prev_stall = 0, done_q = 0;
    logic [26:0] prev_addr;
    logic [15:0] prev_data;

    sd_ddr_load_ctrl #(.NUM_SECTORS(16'd2), .BUSY_TO(16'd100)) dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .sd_init_done(sd_init_done),
        .init_calib_complete(init_calib_complete), .reload(reload),
        .sd_rd_start(sd_rd_start), .sd_rd_sec_addr(sd_rd_sec_addr), .sd_rd_busy(sd_rd_busy),
        .sd_rd_val_en(sd_rd_val_en), .sd_rd_val_data(sd_rd_val_data),
        .ddr_wr_valid(ddr_wr_valid), .ddr_wr_rdy(ddr_wr_rdy), .ddr_wr_addr(ddr_wr_addr),
        .ddr_wr_data(ddr_wr_data), .sys_init_done(sys_init_done), .load_err(load_err),
        .err_code(err_code)
    );

    initial forever #5 sys_clk = ~sys_clk;

    function automatic logic [15:0] data_of(int n);
        return 16'(n * 263 + 'h3C00);
    endfunction

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // DDR ready pattern: 0 = stalled, 1 = always ready, 2 = ready one cycle in four
    initial forever begin
        @(posedge sys_clk);
        #1;
        rdy_ctr++;
        ddr_wr_rdy = rdy_mode == 0 ? 1'b0 : rdy_mode == 1 ? 1'b1 : (rdy_ctr % 4 == 0);
    end

    // scoreboard: each accepted word must be the next one the reader produced, at the next address
    always @(negedge sys_clk) begin
        cyc++;
        if (prev_stall) begin
            check("hold_valid", ddr_wr_valid, 1);
            check("hold_addr", ddr_wr_addr, prev_addr);
            check("hold_data", ddr_wr_data, prev_data);
        end
        prev_stall = ddr_wr_valid && !ddr_wr_rdy;
        prev_addr  = ddr_wr_addr;
        prev_data  = ddr_wr_data;
        if (sd_rd_start) begin
            n_starts++;
            check("free_at_start", 32'(n_push - pop_idx <= 256), 1);
        end
        if (ddr_wr_valid && ddr_wr_rdy) begin
            check("waddr", ddr_wr_addr, pop_idx);
            check("wdata", ddr_wr_data, data_of(pop_idx));
            pop_idx++;
            last_pop = cyc;
        end
        if (sd_rd_val_en) n_push++;
        if (sys_init_done && !done_q) check("done_latency", cyc - last_pop, 2);
        done_q = sys_init_done;
    end

    task automatic wait_start();
        int i = 0;
        while (!sd_rd_start && i < 3000) begin
            @(negedge sys_clk);
            i++;
        end
        check("start_seen", sd_rd_start, 1);
    endtask

    task automatic start_sector(int s);
        wait_start();
        check("sec_addr", sd_rd_sec_addr, 32'd8192 + s);
        @(negedge sys_clk);
        check("start_pulse", sd_rd_start, 0);
    endtask

    task automatic send_sector(int n, bit late);
        @(posedge sys_clk);
        #1 sd_rd_busy = 1;
        for (int i = 0; i < n; i++) begin
            @(posedge sys_clk);
            #1 sd_rd_val_en = 1;
            sd_rd_val_data = data_of(push_idx);
            push_idx++;
            if (late && i == n - 1) sd_rd_busy = 0;
        end
        @(posedge sys_clk);
        #1 sd_rd_val_en = 0;
        sd_rd_busy = 0;
    endtask

    task automatic run_two();
        start_sector(0);
        send_sector(256, 0);
        start_sector(1);
        send_sector(256, 1);
    endtask

    task automatic wait_done();
        int i = 0;
        while (!sys_init_done && i < 5000) begin
            @(negedge sys_clk);
            i++;
        end
        check("init_done", sys_init_done, 1);
        check("pop_total", pop_idx, 512);
        check("no_err", load_err, 0);
        check("no_code", err_code, 0);
    endtask

    task automatic do_reload();
        @(posedge sys_clk);
        #1 reload = 1;
        @(posedge sys_clk);
        #1 reload = 0;
        push_idx = 0;
        pop_idx  = 0;
        n_push   = 0;
    endtask

    task automatic check_reset_outputs();
        check("rst_start", sd_rd_start, 0);
        check("rst_valid", ddr_wr_valid, 0);
        check("rst_done", sys_init_done, 0);
        check("rst_err", load_err, 0);
        check("rst_code", err_code, 0);
        check("rst_sec_addr", sd_rd_sec_addr, 32'd8192);
        check("rst_wr_addr", ddr_wr_addr, 0);
    endtask

    initial begin
        int k;
        repeat (3) @(negedge sys_clk);
        check_reset_outputs();
        @(posedge sys_clk);
        #1 sys_rst = 0;
        sd_init_done = 1;
        repeat (20) @(negedge sys_clk);
        check("no_start_wo_calib", n_starts, 0);
        @(posedge sys_clk);
        #1 init_calib_complete = 1;
        rdy_mode = 1;
        run_two();
        wait_done();

        do_reload();
        rdy_mode = 2;
        run_two();
        wait_done();

        rdy_mode = 1;
        do_reload();
        start_sector(0);
        send_sector(255, 0);
        repeat (10) @(negedge sys_clk);
        check("short_err", load_err, 1);
        check("short_code", err_code, 2);
        check("short_done", sys_init_done, 0);
        check("short_pops", pop_idx, 255);
        do_reload();
        run_two();
        wait_done();

        do_reload();
        wait_start();
        check("to_sec_addr", sd_rd_sec_addr, 32'd8192);
        k = 0;
        while (!load_err && k < 300) begin
            @(negedge sys_clk);
            k++;
        end
        check("busy_to_cycles", k, 100);
        check("busy_to_code", err_code, 1);

        rdy_mode = 0;
        do_reload();
        start_sector(0);
        send_sector(513, 0);
        @(negedge sys_clk);
        check("ovf_err", load_err, 1);
        check("ovf_code", err_code, 3);
        rdy_mode = 1;
        repeat (600) @(negedge sys_clk);
        check("ovf_pops", pop_idx, 512);
        check("ovf_code_held", err_code, 3);

        do_reload();
        start_sector(0);
        send_sector(256, 0);
        start_sector(1);
        @(posedge sys_clk);
        #1 sd_rd_busy = 1;
        repeat (100) begin
            @(posedge sys_clk);
            #1 sd_rd_val_en = 1;
            sd_rd_val_data = data_of(push_idx);
            push_idx++;
        end
        #2 sys_rst = 1;
        sd_rd_busy   = 0;
        sd_rd_val_en = 0;
        push_idx = 0;
        pop_idx  = 0;
        n_push   = 0;
        @(negedge sys_clk);
        check_reset_outputs();
        @(posedge sys_clk);
        #1 sys_rst = 0;
        run_two();
        wait_done();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
